mult_job_sequencer: RTL and testbench

//  Upstream driver for the sequential Multiplier. Buffers operand pairs from a valid/ready source.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_op_fifo.sv | 61 ++++++
 rtl/mult_job_sequencer.sv | 131 +++++++++++++
 tb/tb_mult_job_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier job sequencer: sequencer state
// encoding, default operand width and the default multiplier latency.
package mult_pkg;

    localparam int NUM_BITS_DEFAULT = 7;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        START,
        WAIT,
        HOLD
    } seq_state_t;

    // Cycles the sequential multiplier needs after its start pulse
    function automatic int lat_default(input int n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO feeding the sequencer. Power-of-two depth, so the
// read/write pointers wrap naturally; a separate occupancy counter gives
// exact full/empty. Pushes while full and pops while empty are ignored.
module mult_op_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array needs no reset; only occupied slots are ever read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Upstream driver for the sequential multiplier. Queues operand pairs,
// then runs clear -> start -> wait for one job at a time and offers each
// product on a valid/ready port.
// Optional build macro MULT_ZERO_BYPASS_EN: a pair with a zero operand
// skips the multiplier entirely and reports a zero product straight away.
module mult_job_sequencer
    import mult_pkg::*;
#(
    parameter int NUM_BITS   = NUM_BITS_DEFAULT,
    parameter int DEPTH      = 4,
    parameter int LAT_CYCLES = lat_default(NUM_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_BITS-1:0]   in_multiplier,
    input  logic [NUM_BITS-1:0]   in_multiplicand,
    output logic                  mul_rst,
    output logic                  mul_start,
    output logic [NUM_BITS-1:0]   mul_multiplier,
    output logic [NUM_BITS-1:0]   mul_multiplicand,
    input  logic [2*NUM_BITS-1:0] mul_product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*NUM_BITS-1:0] out_product,
    output logic                  busy
);

    localparam int CW = $clog2(LAT_CYCLES + 1);

    seq_state_t               state;
    logic [CW-1:0]            cnt;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [2*NUM_BITS-1:0]    fifo_dout;
    logic [NUM_BITS-1:0]      pop_a;
    logic [NUM_BITS-1:0]      pop_b;
    logic                     zero_bypass;

    // Held low during reset so the producer sees no room until release
    assign in_ready = rst && !fifo_full;
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign pop_a    = fifo_dout[2*NUM_BITS-1:NUM_BITS];
    assign pop_b    = fifo_dout[NUM_BITS-1:0];

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_bypass = (pop_a == '0) || (pop_b == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    mult_op_fifo #(
        .WIDTH (2 * NUM_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .din   ({in_multiplier, in_multiplicand}),
        .dout  (fifo_dout)
    );

    // Job FSM; every multiplier control and result output is a register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            mul_rst          <= 1'b0;
            mul_start        <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
            busy             <= 1'b0;
        end else begin
            mul_rst   <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        mul_multiplier   <= pop_a;
                        mul_multiplicand <= pop_b;
                        busy             <= 1'b1;
                        if (zero_bypass) begin
                            out_product <= '0;
                            state       <= HOLD;
                        end else begin
                            mul_rst <= 1'b1;
                            state   <= CLR;
                        end
                    end
                end
                CLR: begin
                    mul_start <= 1'b1;
                    state     <= START;
                end
                START: begin
                    cnt   <= CW'(LAT_CYCLES);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        out_product <= mul_product;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Self-checking bench for mult_job_sequencer with a behavioural stand-in
// for the sequential multiplier and a queue-based model of job ordering.
module tb_mult_job_sequencer;

    localparam int NB    = 7;
    localparam int DEPTH = 4;
    localparam int LAT   = 2 * NB + 2;

`ifdef MULT_ZERO_BYPASS_EN
    localparam bit ZBYP = 1'b1;
`else
    localparam bit ZBYP = 1'b0;
`endif

    typedef struct packed {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
    } pair_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NB-1:0]   in_multiplier;
    logic [NB-1:0]   in_multiplicand;
    logic            mul_rst;
    logic            mul_start;
    logic [NB-1:0]   mul_multiplier;
    logic [NB-1:0]   mul_multiplicand;
    logic [2*NB-1:0] mul_product;
    logic            out_valid;
    logic            out_ready;
    logic [2*NB-1:0] out_product;
    logic            busy;

    int errors = 0;
    int checks = 0;
    bit checksOn = 1'b0;
    int cycleCount = 0;
    int lastPushEdge = 0;
    int rstCount = 0;
    int startCount = 0;
    int validCount = 0;
    logic [2*NB-1:0] resultLog [$];

    // Job model state
    pair_t         jobQ [$];
    logic          jobActive = 1'b0;
    int            k = 0;
    logic          bypassJob = 1'b0;
    logic [NB-1:0] lastA = '0;
    logic [NB-1:0] lastB = '0;

    // Multiplier stand-in
    logic [NB-1:0]   ma = '0;
    logic [NB-1:0]   mb = '0;
    logic [2*NB-1:0] mprod = '0;
    int              mcnt = 0;

    assign mul_product = mprod;

    mult_job_sequencer #(
        .NUM_BITS   (NB),
        .DEPTH      (DEPTH),
        .LAT_CYCLES (LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_multiplier    (in_multiplier),
        .in_multiplicand  (in_multiplicand),
        .mul_rst          (mul_rst),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Multiplier stand-in: product only becomes correct LAT cycles after start
    always @(posedge clk) begin
        if (mul_rst) begin
            mprod <= '0;
            mcnt  <= 0;
        end else if (mul_start) begin
            ma   <= mul_multiplier;
            mb   <= mul_multiplicand;
            mcnt <= LAT;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mprod <= {{NB{1'b0}}, ma} * {{NB{1'b0}}, mb};
            end
        end
    end

    // Edge counter and accepted-result log
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (rst && out_valid && out_ready) begin
            resultLog.push_back(out_product);
        end
    end

    // Pulse and valid-cycle tallies
    always @(negedge clk) begin
        if (mul_rst)   rstCount   <= rstCount + 1;
        if (mul_start) startCount <= startCount + 1;
        if (out_valid) validCount <= validCount + 1;
    end

    // Job model: queue of pairs, one in flight, timeline counted from its pop
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            jobQ.delete();
            jobActive <= 1'b0;
            k         <= 0;
            bypassJob <= 1'b0;
            lastA     <= '0;
            lastB     <= '0;
        end else begin : model
            int   fifoCnt;
            logic validNow;
            logic pushNow;
            fifoCnt  = jobQ.size() - (jobActive ? 1 : 0);
            validNow = jobActive && (k >= (bypassJob ? 1 : LAT + 3));
            pushNow  = in_valid && (fifoCnt < DEPTH);
            if (!jobActive && jobQ.size() > 0) begin
                jobActive <= 1'b1;
                k         <= 0;
                lastA     <= jobQ[0].a;
                lastB     <= jobQ[0].b;
                bypassJob <= ZBYP && ((jobQ[0].a == 0) || (jobQ[0].b == 0));
            end else if (validNow && out_ready) begin
                jobActive <= 1'b0;
                void'(jobQ.pop_front());
            end else if (jobActive && k < 10000) begin
                k <= k + 1;
            end
            if (pushNow) begin
                jobQ.push_back({in_multiplier, in_multiplicand});
            end
        end
    end

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        if (checksOn) begin : compare
            int              fifoCnt;
            logic            expValid;
            logic [2*NB-1:0] expProd;
            fifoCnt  = jobQ.size() - (jobActive ? 1 : 0);
            expValid = jobActive && (k >= (bypassJob ? 1 : LAT + 3));
            checkOutput("in_ready", in_ready, rst && (fifoCnt < DEPTH));
            checkOutput("busy", busy, jobActive);
            checkOutput("mul_rst", mul_rst, jobActive && !bypassJob && (k == 0));
            checkOutput("mul_start", mul_start, jobActive && !bypassJob && (k == 1));
            checkOutput("out_valid", out_valid, expValid);
            checkOutput("mul_multiplier", mul_multiplier, lastA);
            checkOutput("mul_multiplicand", mul_multiplicand, lastB);
            if (expValid) begin
                expProd = {{NB{1'b0}}, jobQ[0].a} * {{NB{1'b0}}, jobQ[0].b};
                checkOutput("out_product", out_product, expProd);
            end
        end
    end

    // Offer one pair, wait (bounded) for acceptance, return on the following negedge
    task automatic applyStimulus(input logic [NB-1:0] a, input logic [NB-1:0] b);
        int waited = 0;
        in_valid        = 1'b1;
        in_multiplier   = a;
        in_multiplicand = b;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("push_timeout", in_ready, 1);
        end
        @(negedge clk);
        lastPushEdge = cycleCount;
        in_valid = 1'b0;
    endtask

    task automatic waitValid(input string name, input int maxCycles);
        int n = 0;
        while (!out_valid && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checkOutput(name, out_valid, 1);
        end
    endtask

    task automatic waitResults(input string name, input int target, input int maxCycles);
        int n = 0;
        while (resultLog.size() < target && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, resultLog.size(), target);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int r0;
        int s0;
        int v0;
        logic [31:0] exp4 [5];

        rst = 1'b1;
        in_valid = 1'b0;
        in_multiplier = '0;
        in_multiplicand = '0;
        out_ready = 1'b0;
        #1 rst = 1'b0;
        #2;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_product", out_product, 0);
        checkOutput("reset_mul_rst", mul_rst, 0);
        checkOutput("reset_mul_start", mul_start, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        checksOn = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", in_ready, 1);

        // Single job: latency, product and one clear/start pair
        $display("[TB] test 1: 15 x 15");
        out_ready = 1'b1;
        r0 = rstCount;
        s0 = startCount;
        applyStimulus(7'd15, 7'd15);
        waitValid("t1_valid_timeout", 60);
        checkOutput("t1_latency", cycleCount - lastPushEdge, LAT + 4);
        checkOutput("t1_product", out_product, 225);
        repeat (3) @(negedge clk);
        checkOutput("t1_clear_pulses", rstCount - r0, 1);
        checkOutput("t1_start_pulses", startCount - s0, 1);

        // Back-to-back jobs come out in order, each with its own clear/start
        $display("[TB] test 2: 92 x 75 then 1 x 2");
        base = resultLog.size();
        r0 = rstCount;
        s0 = startCount;
        applyStimulus(7'd92, 7'd75);
        applyStimulus(7'd1, 7'd2);
        waitResults("t2_result_count", base + 2, 120);
        checkOutput("t2_first", resultLog[base], 6900);
        checkOutput("t2_second", resultLog[base + 1], 2);
        checkOutput("t2_clear_pulses", rstCount - r0, 2);
        checkOutput("t2_start_pulses", startCount - s0, 2);

        // Zero operand
        $display("[TB] test 3: 0 x 12");
        repeat (2) @(negedge clk);
        s0 = startCount;
        applyStimulus(7'd0, 7'd12);
        waitValid("t3_valid_timeout", 60);
        checkOutput("t3_latency", cycleCount - lastPushEdge, ZBYP ? 2 : LAT + 4);
        checkOutput("t3_product", out_product, 0);
        repeat (3) @(negedge clk);
        checkOutput("t3_start_pulses", startCount - s0, ZBYP ? 0 : 1);

        // Back-pressure: one job in flight plus a full FIFO
        $display("[TB] test 4: back-pressure with 5 pairs");
        out_ready = 1'b0;
        base = resultLog.size();
        exp4[0] = 12;
        exp4[1] = 110;
        exp4[2] = 16129;
        exp4[3] = 128;
        exp4[4] = 63;
        applyStimulus(7'd3, 7'd4);
        applyStimulus(7'd10, 7'd11);
        applyStimulus(7'd127, 7'd127);
        applyStimulus(7'd64, 7'd2);
        applyStimulus(7'd7, 7'd9);
        checkOutput("t4_in_ready_full", in_ready, 0);
        waitValid("t4_valid_timeout", 60);
        checkOutput("t4_first_product", out_product, 12);
        repeat (6) @(negedge clk);
        checkOutput("t4_valid_held", out_valid, 1);
        checkOutput("t4_product_stable", out_product, 12);
        checkOutput("t4_still_full", in_ready, 0);
        out_ready = 1'b1;
        waitResults("t4_result_count", base + 5, 250);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t4_result%0d", i), resultLog[base + i], exp4[i]);
        end

        // Reset in the middle of a multiply discards everything
        $display("[TB] test 5: reset mid-job");
        repeat (2) @(negedge clk);
        base = resultLog.size();
        applyStimulus(7'd100, 7'd100);
        applyStimulus(7'd20, 7'd30);
        repeat (8) @(negedge clk);
        checkOutput("t5_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_in_ready", in_ready, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_out_product", out_product, 0);
        checkOutput("t5_mul_rst", mul_rst, 0);
        checkOutput("t5_mul_start", mul_start, 0);
        checkOutput("t5_mul_multiplier", mul_multiplier, 0);
        checkOutput("t5_mul_multiplicand", mul_multiplicand, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        v0 = validCount;
        repeat (40) @(negedge clk);
        checkOutput("t5_no_stale_valid", validCount - v0, 0);
        checkOutput("t5_no_stale_result", resultLog.size() - base, 0);
        checkOutput("t5_idle_after", busy, 0);
        applyStimulus(7'd6, 7'd7);
        waitResults("t5_result_count", base + 1, 60);
        checkOutput("t5_fresh_result", resultLog[base], 42);
        repeat (5) @(negedge clk);
        checkOutput("t5_single_result", resultLog.size() - base, 1);

        checksOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
